// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
// Width codes follow RISC-V funct3 for loads and stores.
package mem_arbiter_pkg;

    localparam logic [2:0] LD_BS = 3'b000;
    localparam logic [2:0] LD_HS = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic        owner;
        logic        wen;
        logic [2:0]  func;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [2:0]  lsu_func;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [2:0]  mem_func;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        err;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_wen, lsu_func,
        input  lsu_addr, lsu_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_wen, mem_func,
        output mem_addr, mem_wdata, err
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_wen, lsu_func,
        output lsu_addr, lsu_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_func,
        input  mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; on contention the side that did
// not win the previous acceptance gets the grant.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic accept,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    logic last;

    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        unique case (1'b1)
            (req_ifu && req_lsu): begin
                gnt_lsu = (last == OWN_IFU);
                gnt_ifu = (last == OWN_LSU);
            end
            (req_ifu && !req_lsu): gnt_ifu = 1'b1;
            (!req_ifu && req_lsu): gnt_lsu = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= OWN_IFU;
        end else if (accept) begin
            last <= gnt_lsu ? OWN_LSU : OWN_IFU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between IFU and LSU, one
// transaction in flight, with a response watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 10
) (
    input logic          clk,
    input logic          rstn,
    mem_arbiter_if.slave bus
);

    state_t           state;
    req_t             lat;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic gnt_ifu, gnt_lsu;
    logic idle, in_req, in_wait;
    logic acc_ifu, acc_lsu, accept;
    logic hit, tmo, done;
    logic [31:0] rdata;

    assign idle    = (state == IDLE);
    assign in_req  = (state == REQ);
    assign in_wait = (state == WAIT);

    rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req_ifu (bus.ifu_req_valid),
        .req_lsu (bus.lsu_req_valid),
        .accept  (accept),
        .gnt_ifu (gnt_ifu),
        .gnt_lsu (gnt_lsu)
    );

    // Ready is masked by rstn so nothing is offered while held in reset.
    assign bus.ifu_req_ready = rstn && idle && gnt_ifu;
    assign bus.lsu_req_ready = rstn && idle && gnt_lsu;

    assign acc_ifu = bus.ifu_req_valid && bus.ifu_req_ready;
    assign acc_lsu = bus.lsu_req_valid && bus.lsu_req_ready;
    assign accept  = acc_ifu || acc_lsu;

    assign hit  = in_wait && bus.mem_resp_valid;
    assign tmo  = in_wait && !bus.mem_resp_valid &&
                  (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign done = hit || tmo;

    assign rdata = hit ? bus.mem_rdata : 32'h0;

    assign bus.ifu_resp_valid = done && (lat.owner == OWN_IFU);
    assign bus.lsu_resp_valid = done && (lat.owner == OWN_LSU);
    assign bus.ifu_rdata = bus.ifu_resp_valid ? rdata : 32'h0;
    assign bus.lsu_rdata = bus.lsu_resp_valid ? rdata : 32'h0;

    assign bus.mem_req_valid = in_req;
    assign bus.mem_wen   = in_req && lat.wen;
    assign bus.mem_func  = in_req ? lat.func  : 3'h0;
    assign bus.mem_addr  = in_req ? lat.addr  : 32'h0;
    assign bus.mem_wdata = in_req ? lat.wdata : 32'h0;

    assign bus.err = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            lat   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc_lsu) begin
                        lat.owner <= OWN_LSU;
                        lat.wen   <= bus.lsu_wen;
                        lat.func  <= bus.lsu_func;
                        lat.addr  <= bus.lsu_addr;
                        lat.wdata <= bus.lsu_wdata;
                        state     <= REQ;
                    end else if (acc_ifu) begin
                        lat.owner <= OWN_IFU;
                        lat.wen   <= 1'b0;
                        lat.func  <= LD_W;
                        lat.addr  <= bus.ifu_addr;
                        lat.wdata <= 32'h0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (tmo) err_q <= 1'b1;
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
